// File: rtl/alu_seq.sv
// Registered W-bit ALU with accumulator and multi-cycle shift/multiply under start/busy/done.
// Define ALU_MUL_EN to compile in the shift-add multiplier (op 1011); otherwise 1011 is reserved.
module alu_seq #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(W)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_in_i,
    input  logic         src_acc_i,
    output logic [W-1:0] r_o,
    output logic [W-1:0] hi_o,
    output logic         zero_o,
    output logic         carry_o,
    output logic         sign_o,
    output logic         ovf_o,
    output logic         ill_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift
`ifdef ALU_MUL_EN
        , StMult
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  r_q, r_d;
    logic          zero_q, zero_d, carry_q, carry_d, sign_q, sign_d, ovf_q, ovf_d;
    logic          ill_q, ill_d, done_q, done_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sh_op_q, sh_op_d;

    logic [W-1:0]  x, addend, sh_nxt, res;
    logic [SW-1:0] k;
    logic [W:0]    sum;
    logic          cin, ovf_add, sh_out, fin, res_c, res_v;
`ifdef ALU_MUL_EN
    logic [W-1:0]  hi_q, hi_d, ph_q, ph_d, mc_q, mc_d, res_hi;
    logic [W:0]    madd;
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        done_d  = 1'b0;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        sh_op_d = sh_op_q;
        fin     = 1'b0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
`ifdef ALU_MUL_EN
        hi_d    = hi_q;
        ph_d    = ph_q;
        mc_d    = mc_q;
        res_hi  = '0;
        madd    = {1'b0, ph_q} + (sh_q[0] ? {1'b0, mc_q} : '0);
`endif

        x = src_acc_i ? r_q : a_i;
        k = b_i[SW-1:0];

        // ADD/SUB/INC/DEC share one adder; low op bits select the addend and carry-in.
        unique case (op_i[1:0])
            2'b00:   begin addend = b_i;  cin = c_in_i; end
            2'b01:   begin addend = ~b_i; cin = 1'b1;   end
            2'b10:   begin addend = '0;   cin = 1'b1;   end
            default: begin addend = '1;   cin = 1'b0;   end
        endcase
        sum     = {1'b0, x} + {1'b0, addend} + {{W{1'b0}}, cin};
        ovf_add = (x[W-1] == addend[W-1]) && (sum[W-1] != x[W-1]);

        case (sh_op_q)
            2'b00:   begin sh_nxt = {sh_q[W-2:0], 1'b0};     sh_out = sh_q[W-1]; end
            2'b01:   begin sh_nxt = {1'b0, sh_q[W-1:1]};     sh_out = sh_q[0];   end
            default: begin sh_nxt = {sh_q[W-1], sh_q[W-1:1]}; sh_out = sh_q[0];  end
        endcase

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    case (op_i)
                        4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                            fin   = 1'b1;
                            res   = sum[W-1:0];
                            res_c = sum[W];
                            res_v = ovf_add;
                        end
                        4'b0100: begin fin = 1'b1; res = x & b_i; end
                        4'b0101: begin fin = 1'b1; res = x | b_i; end
                        4'b0110: begin fin = 1'b1; res = x ^ b_i; end
                        4'b0111: begin fin = 1'b1; res = ~x;      end
                        4'b1000, 4'b1001, 4'b1010: begin
                            if (k == '0) begin
                                fin = 1'b1;
                                res = x;
                            end else begin
                                sh_d    = x;
                                cnt_d   = CW'(k);
                                sh_op_d = op_i[1:0];
                                state_d = StShift;
                            end
                        end
`ifdef ALU_MUL_EN
                        4'b1011: begin
                            mc_d    = x;
                            sh_d    = b_i;
                            ph_d    = '0;
                            cnt_d   = CW'(W);
                            state_d = StMult;
                        end
`endif
                        default: begin
                            // Reserved: results and flags hold, only ill and done move.
                            ill_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            StShift: begin
                sh_d  = sh_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    fin     = 1'b1;
                    res     = sh_nxt;
                    res_c   = sh_out;
                    state_d = StIdle;
                end
            end
`ifdef ALU_MUL_EN
            StMult: begin
                // {ph, sh} shifts right one place per step; sh ends as the low product half.
                ph_d  = madd[W:1];
                sh_d  = {madd[0], sh_q[W-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    fin     = 1'b1;
                    res     = {madd[0], sh_q[W-1:1]};
                    res_hi  = madd[W:1];
                    res_c   = |madd[W:1];
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (fin) begin
            r_d     = res;
            zero_d  = (res == '0);
            sign_d  = res[W-1];
            carry_d = res_c;
            ovf_d   = res_v;
            ill_d   = 1'b0;
            done_d  = 1'b1;
`ifdef ALU_MUL_EN
            hi_d    = res_hi;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            r_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            done_q  <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            sh_op_q <= '0;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
            ph_q    <= '0;
            mc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sh_op_q <= sh_op_d;
`ifdef ALU_MUL_EN
            hi_q    <= hi_d;
            ph_q    <= ph_d;
            mc_q    <= mc_d;
`endif
        end
    end

    assign r_o     = r_q;
    assign zero_o  = zero_q;
    assign carry_o = carry_q;
    assign sign_o  = sign_q;
    assign ovf_o   = ovf_q;
    assign ill_o   = ill_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != StIdle);
`ifdef ALU_MUL_EN
    assign hi_o    = hi_q;
`else
    assign hi_o    = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (W=8) plus hand sequences for
// back-to-back issue, start-while-busy, reset mid-traffic and abort.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'h0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       c_in = 1'b0, src_acc = 1'b0;
    logic [7:0] r, hi;
    logic       zero, carry, sign, ovf, ill, busy, done;

    int checks = 0;
    int errors = 0;

    alu_seq #(.W(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .c_in_i   (c_in),
        .src_acc_i(src_acc),
        .r_o      (r),
        .hi_o     (hi),
        .zero_o   (zero),
        .carry_o  (carry),
        .sign_o   (sign),
        .ovf_o    (ovf),
        .ill_o    (ill),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sacc;
        logic [7:0] r;
        logic [7:0] hi;
        logic [3:0] flg;   // {zero, carry, sign, ovf}
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; lat=0 if done never arrives.
    task automatic run_op(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sa, output int lat, output logic busy1);
        @(negedge clk);
        op = o; a = av; b = bv; c_in = ci; src_acc = sa; start = 1'b1;
        lat = 0;
        busy1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 1) busy1 = busy;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " r"}, 32'(r), 32'h00);
        check({tag, " hi"}, 32'(hi), 32'h00);
        check({tag, " flags"}, 32'({zero, carry, sign, ovf}), 32'h0);
        check({tag, " ill"}, 32'(ill), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
    endtask

    initial begin
        int lat;
        logic b1;
        int dones;
        logic [3:0] long_op;

        vecs[0]  = '{4'b0000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 4'b1100, 1'b0, 1};
        vecs[1]  = '{4'b0010, 8'hAA, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 4'b0000, 1'b0, 1};
        vecs[2]  = '{4'b0001, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 8'h00, 4'b0101, 1'b0, 1};
        vecs[3]  = '{4'b0111, 8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, 8'h00, 4'b0010, 1'b0, 1};
        vecs[4]  = '{4'b0000, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 8'h00, 4'b0011, 1'b0, 1};
        vecs[5]  = '{4'b0011, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00, 4'b0010, 1'b0, 1};
        vecs[6]  = '{4'b0100, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00, 4'b0000, 1'b0, 1};
        vecs[7]  = '{4'b0101, 8'h50, 8'h0A, 1'b0, 1'b0, 8'h5A, 8'h00, 4'b0000, 1'b0, 1};
        vecs[8]  = '{4'b0110, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 4'b1000, 1'b0, 1};
        vecs[9]  = '{4'b1000, 8'h81, 8'h03, 1'b0, 1'b0, 8'h08, 8'h00, 4'b0000, 1'b0, 4};
        vecs[10] = '{4'b1001, 8'h81, 8'h01, 1'b0, 1'b0, 8'h40, 8'h00, 4'b0100, 1'b0, 2};
        vecs[11] = '{4'b1010, 8'h83, 8'h02, 1'b0, 1'b0, 8'hE0, 8'h00, 4'b0110, 1'b0, 3};
        vecs[12] = '{4'b1000, 8'h5A, 8'h08, 1'b0, 1'b0, 8'h5A, 8'h00, 4'b0000, 1'b0, 1};
        vecs[13] = '{4'b1000, 8'h03, 8'h07, 1'b0, 1'b0, 8'h80, 8'h00, 4'b0110, 1'b0, 8};
        vecs[14] = '{4'b1100, 8'h12, 8'h34, 1'b0, 1'b0, 8'h80, 8'h00, 4'b0110, 1'b1, 1};
`ifdef ALU_MUL_EN
        vecs[15] = '{4'b1011, 8'h14, 8'h0F, 1'b0, 1'b0, 8'h2C, 8'h01, 4'b0100, 1'b0, 9};
        vecs[16] = '{4'b0000, 8'h99, 8'h00, 1'b0, 1'b1, 8'h2C, 8'h00, 4'b0000, 1'b0, 1};
        long_op  = 4'b1011;
`else
        vecs[15] = '{4'b1011, 8'h14, 8'h0F, 1'b0, 1'b0, 8'h80, 8'h00, 4'b0110, 1'b1, 1};
        vecs[16] = '{4'b0000, 8'h99, 8'h00, 1'b0, 1'b1, 8'h80, 8'h00, 4'b0010, 1'b0, 1};
        long_op  = 4'b1000;
`endif

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_in");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("reset_out");

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sacc, lat, b1);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d busy_after_accept", i), 32'(b1), 32'(vecs[i].lat > 1));
            check($sformatf("v%0d r", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("v%0d hi", i), 32'(hi), 32'(vecs[i].hi));
            check($sformatf("v%0d flags", i), 32'({zero, carry, sign, ovf}), 32'(vecs[i].flg));
            check($sformatf("v%0d ill", i), 32'(ill), 32'(vecs[i].ill));
            check($sformatf("v%0d busy_at_done", i), 32'(busy), 32'h0);
        end

        // Back-to-back single-cycle ops with start held high.
        @(negedge clk);
        op = 4'b0000; a = 8'h01; b = 8'h01; c_in = 1'b0; src_acc = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b first done", 32'(done), 32'h1);
        check("b2b first r", 32'(r), 32'h02);
        op = 4'b0010; src_acc = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second done", 32'(done), 32'h1);
        check("b2b second r", 32'(r), 32'h03);
        @(posedge clk);
        #1;
        check("b2b done drops", 32'(done), 32'h0);

        // SHL with a start pulse during busy: ignored, not queued.
        @(negedge clk);
        op = 4'b1000; a = 8'h81; b = 8'h03; src_acc = 1'b0; start = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (n == 1) begin
                @(negedge clk);
                op = 4'b0000; a = 8'h01; b = 8'h01; start = 1'b1;
            end
        end
        check("busy_start latency", 32'(lat), 32'd4);
        check("busy_start r", 32'(r), 32'h08);
        check("busy_start carry", 32'(carry), 32'h0);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("busy_start no queued op", 32'(dones), 32'd0);
        check("busy_start r held", 32'(r), 32'h08);

        // Reset held two cycles in the middle of a shift.
        @(negedge clk);
        op = 4'b1000; a = 8'h03; b = 8'h07; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a long op at its fourth cycle.
        run_op(4'b0000, 8'h11, 8'h22, 1'b0, 1'b0, lat, b1);
        check("pre_abort r", 32'(r), 32'h33);
        @(negedge clk);
        op = long_op; a = 8'h14; b = 8'h07; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 32'(busy), 32'h0);
        check("abort r", 32'(r), 32'h00);
        check("abort done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort no late done", 32'(dones), 32'd0);
        run_op(4'b0000, 8'h05, 8'h03, 1'b0, 1'b0, lat, b1);
        check("post_abort latency", 32'(lat), 32'd1);
        check("post_abort r", 32'(r), 32'h08);
        check("post_abort flags", 32'({zero, carry, sign, ovf}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
